// File: rtl/processing_core_param.sv
// Parametrised multicycle accumulator CPU with handshaked instruction/data
// memories, START/PROCESS_FINISHED run control, optional MUL and illegal-op trap.
module processing_core_param #(
  parameter int DATA_W   = 16,
  parameter int IADDR_W  = 8,
  parameter int NUM_REGS = 4,
  parameter int MUL_EN   = 1
) (
  input  logic               MAIN_CLOCK,
  input  logic               RESET,
  input  logic               START,
  output logic               IMEM_REQ,
  output logic [IADDR_W-1:0] IMEM_ADDR,
  input  logic [15:0]        IMEM_DATA,
  input  logic               IMEM_ACK,
  output logic               MEM_REQ,
  output logic               MEM_WE,
  output logic [DATA_W-1:0]  MEM_ADDR,
  output logic [DATA_W-1:0]  MEM_WDATA,
  input  logic [DATA_W-1:0]  MEM_RDATA,
  input  logic               MEM_ACK,
  output logic               BUSY,
  output logic               PROCESS_FINISHED,
  output logic               ERR,
  output logic               Z_FLAG,
  output logic [DATA_W-1:0]  REG_AC
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_EXEC, S_MEM, S_HALTED} state_t;
  typedef enum logic [3:0] {
    OP_NOP, OP_LDI, OP_LDM, OP_STM, OP_MVA, OP_ADD, OP_SUB, OP_MUL,
    OP_LDAC, OP_STAC, OP_INC, OP_JZ, OP_JNZ, OP_JMP, OP_ILL, OP_HALT
  } op_t;

  localparam logic [4:0] NREG = 5'(NUM_REGS);

  state_t              state;
  logic [IADDR_W-1:0]  pc;
  logic [15:0]         ir;
  logic [DATA_W-1:0]   ac;
  logic [DATA_W-1:0]   ar;
  logic [DATA_W-1:0]   regs [16];

  op_t                 op;
  logic [3:0]          rn_idx;
  logic [7:0]          imm;
  logic                rn_ok;
  logic                illegal;
  logic [DATA_W-1:0]   rn_val;
  logic [DATA_W-1:0]   alu_res;
  logic [2*DATA_W-1:0] prod;
  logic                reg_we;
  logic [DATA_W-1:0]   reg_wdata;

  assign op        = op_t'(ir[15:12]);
  assign rn_idx    = ir[11:8];
  assign imm       = ir[7:0];
  assign rn_ok     = {1'b0, rn_idx} < NREG;
  assign rn_val    = rn_ok ? regs[rn_idx] : '0;
  assign illegal   = (op == OP_ILL) || ((op == OP_MUL) && (MUL_EN == 0));
  assign prod      = {{DATA_W{1'b0}}, ac} * {{DATA_W{1'b0}}, rn_val};
  assign IMEM_ADDR = pc;
  assign MEM_ADDR  = ar;
  assign REG_AC    = ac;

  always_comb begin
    case (op)
      OP_ADD:  alu_res = ac + rn_val;
      OP_SUB:  alu_res = ac - rn_val;
      OP_MUL:  alu_res = prod[DATA_W-1:0];
      default: alu_res = rn_val;
    endcase
  end

  // Single register write port shared by EXEC-stage ops and load completion.
  always_comb begin
    reg_we    = 1'b0;
    reg_wdata = '0;
    if (state == S_EXEC) begin
      case (op)
        OP_LDI:  begin reg_we = 1'b1; reg_wdata = DATA_W'(imm);           end
        OP_STAC: begin reg_we = 1'b1; reg_wdata = ac;                     end
        OP_INC:  begin reg_we = 1'b1; reg_wdata = rn_val + DATA_W'(1);    end
        default: ;
      endcase
    end else if ((state == S_MEM) && MEM_ACK && !MEM_WE) begin
      reg_we    = 1'b1;
      reg_wdata = MEM_RDATA;
    end
  end

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_we && rn_ok) begin
      regs[rn_idx] <= reg_wdata;
    end
  end

  always_ff @(posedge MAIN_CLOCK or posedge RESET) begin
    if (RESET) begin
      state            <= S_IDLE;
      pc               <= '0;
      ir               <= '0;
      ac               <= '0;
      ar               <= '0;
      Z_FLAG           <= 1'b0;
      ERR              <= 1'b0;
      IMEM_REQ         <= 1'b0;
      MEM_REQ          <= 1'b0;
      MEM_WE           <= 1'b0;
      MEM_WDATA        <= '0;
      BUSY             <= 1'b0;
      PROCESS_FINISHED <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_HALTED: begin
          if (START) begin
            pc               <= '0;
            ERR              <= 1'b0;
            state            <= S_FETCH;
            IMEM_REQ         <= 1'b1;
            BUSY             <= 1'b1;
            PROCESS_FINISHED <= 1'b0;
          end
        end
        S_FETCH: begin
          if (IMEM_ACK) begin
            ir       <= IMEM_DATA;
            pc       <= pc + IADDR_W'(1);
            IMEM_REQ <= 1'b0;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          state    <= S_FETCH;
          IMEM_REQ <= 1'b1;
          if (illegal) begin
            ERR              <= 1'b1;
            state            <= S_HALTED;
            IMEM_REQ         <= 1'b0;
            BUSY             <= 1'b0;
            PROCESS_FINISHED <= 1'b1;
          end else begin
            case (op)
              OP_LDM, OP_STM: begin
                state     <= S_MEM;
                IMEM_REQ  <= 1'b0;
                MEM_REQ   <= 1'b1;
                MEM_WE    <= (op == OP_STM);
                MEM_WDATA <= rn_val;
              end
              OP_MVA: ar <= rn_val;
              OP_ADD, OP_SUB, OP_MUL, OP_LDAC: begin
                ac     <= alu_res;
                Z_FLAG <= (alu_res == '0);
              end
              OP_JZ:  if (Z_FLAG)  pc <= IADDR_W'(imm);
              OP_JNZ: if (!Z_FLAG) pc <= IADDR_W'(imm);
              OP_JMP: pc <= IADDR_W'(imm);
              OP_HALT: begin
                state            <= S_HALTED;
                IMEM_REQ         <= 1'b0;
                BUSY             <= 1'b0;
                PROCESS_FINISHED <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_MEM: begin
          if (MEM_ACK) begin
            MEM_REQ  <= 1'b0;
            MEM_WE   <= 1'b0;
            state    <= S_FETCH;
            IMEM_REQ <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_processing_core_param.sv
// Self-checking bench for processing_core_param: default build plus a
// NUM_REGS=2 / MUL_EN=0 build, with programmable-latency memory responders.
module tb_processing_core_param;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- DUT A: default parameters ----------------
  logic        a_start = 1'b0;
  logic        a_imem_req, a_mem_req, a_mem_we, a_busy, a_fin, a_err, a_z;
  logic [7:0]  a_imem_addr;
  logic [15:0] a_imem_data = '0;
  logic        a_imem_ack = 1'b0;
  logic [15:0] a_mem_addr, a_mem_wdata, a_ac;
  logic [15:0] a_mem_rdata = '0;
  logic        a_mem_ack = 1'b0;

  processing_core_param #(.DATA_W(16), .IADDR_W(8), .NUM_REGS(4), .MUL_EN(1)) u_dut_a (
    .MAIN_CLOCK(clk), .RESET(rst), .START(a_start),
    .IMEM_REQ(a_imem_req), .IMEM_ADDR(a_imem_addr), .IMEM_DATA(a_imem_data), .IMEM_ACK(a_imem_ack),
    .MEM_REQ(a_mem_req), .MEM_WE(a_mem_we), .MEM_ADDR(a_mem_addr), .MEM_WDATA(a_mem_wdata),
    .MEM_RDATA(a_mem_rdata), .MEM_ACK(a_mem_ack),
    .BUSY(a_busy), .PROCESS_FINISHED(a_fin), .ERR(a_err), .Z_FLAG(a_z), .REG_AC(a_ac)
  );

  // ---------------- DUT B: two registers, no multiplier ----------------
  logic        b_start = 1'b0;
  logic        b_imem_req, b_mem_req, b_mem_we, b_busy, b_fin, b_err, b_z;
  logic [7:0]  b_imem_addr;
  logic [15:0] b_imem_data = '0;
  logic        b_imem_ack = 1'b0;
  logic [15:0] b_mem_addr, b_mem_wdata, b_ac;
  logic [15:0] b_mem_rdata = '0;
  logic        b_mem_ack = 1'b0;

  processing_core_param #(.DATA_W(16), .IADDR_W(8), .NUM_REGS(2), .MUL_EN(0)) u_dut_b (
    .MAIN_CLOCK(clk), .RESET(rst), .START(b_start),
    .IMEM_REQ(b_imem_req), .IMEM_ADDR(b_imem_addr), .IMEM_DATA(b_imem_data), .IMEM_ACK(b_imem_ack),
    .MEM_REQ(b_mem_req), .MEM_WE(b_mem_we), .MEM_ADDR(b_mem_addr), .MEM_WDATA(b_mem_wdata),
    .MEM_RDATA(b_mem_rdata), .MEM_ACK(b_mem_ack),
    .BUSY(b_busy), .PROCESS_FINISHED(b_fin), .ERR(b_err), .Z_FLAG(b_z), .REG_AC(b_ac)
  );

  logic [15:0] rom_a [256];
  logic [15:0] rom_b [256];
  logic [15:0] dmem  [256];

  logic [31:0] write_q [$];   // expected stores: {addr, data}
  logic [15:0] exp_ac_q [$];  // expected accumulator at end of each run

  int idly = 0, ddly = 0;
  int icnt = 0, dcnt = 0, i_len = 0, d_len = 0;
  bit len_chk_en = 1'b1;
  int sub_fetch = 0;
  bit wrap_seen = 1'b0;
  logic [7:0]  last_fetch = '0, cap_iaddr = '0;
  logic [15:0] cap_addr = '0, cap_wd = '0;
  logic        cap_we = 1'b0;

  // Memory responders for DUT A, driven on the falling edge.
  always @(negedge clk) begin
    check("req_exclusive", {31'b0, a_imem_req & a_mem_req}, 32'd0);

    if (a_imem_req && !a_imem_ack) begin
      if (icnt == 0) cap_iaddr = a_imem_addr;
      else check("imem_addr_stable", {24'b0, a_imem_addr}, {24'b0, cap_iaddr});
      if (icnt == idly) begin
        a_imem_ack  = 1'b1;
        a_imem_data = rom_a[a_imem_addr];
        if (a_imem_addr == 8'h04) sub_fetch++;
        if (a_imem_addr == 8'h00 && last_fetch == 8'hFF) wrap_seen = 1'b1;
        last_fetch = a_imem_addr;
      end else icnt++;
    end else begin
      a_imem_ack = 1'b0;
      icnt = 0;
    end
    if (a_imem_req) i_len++;
    else if (i_len != 0) begin
      if (len_chk_en) check("imem_req_len", i_len, idly + 1);
      i_len = 0;
    end

    if (a_mem_req && !a_mem_ack) begin
      if (dcnt == 0) begin
        cap_addr = a_mem_addr; cap_we = a_mem_we; cap_wd = a_mem_wdata;
      end else begin
        check("mem_addr_stable", {16'b0, a_mem_addr}, {16'b0, cap_addr});
        check("mem_we_stable", {31'b0, a_mem_we}, {31'b0, cap_we});
        check("mem_wdata_stable", {16'b0, a_mem_wdata}, {16'b0, cap_wd});
      end
      if (dcnt == ddly) begin
        a_mem_ack = 1'b1;
        if (a_mem_we) begin
          dmem[a_mem_addr[7:0]] = a_mem_wdata;
          if (write_q.size() == 0) check("unexpected_write", 32'd1, 32'd0);
          else check("store_addr_data", {a_mem_addr, a_mem_wdata}, write_q.pop_front());
        end else a_mem_rdata = dmem[a_mem_addr[7:0]];
      end else dcnt++;
    end else begin
      a_mem_ack = 1'b0;
      dcnt = 0;
    end
    if (a_mem_req) d_len++;
    else if (d_len != 0) begin
      if (len_chk_en) check("mem_req_len", d_len, ddly + 1);
      d_len = 0;
    end
  end

  always @(negedge clk) begin
    if (b_imem_req && !b_imem_ack) begin
      b_imem_ack  = 1'b1;
      b_imem_data = rom_b[b_imem_addr];
    end else b_imem_ack = 1'b0;
  end

  task automatic clear_rom_a();
    for (int i = 0; i < 256; i++) rom_a[i] = 16'hF000;
  endtask

  task automatic start_a();
    @(negedge clk) a_start = 1'b1;
    @(negedge clk) a_start = 1'b0;
  endtask

  task automatic wait_a(input logic [15:0] exp_ac, input int maxc, output int n);
    exp_ac_q.push_back(exp_ac);
    n = 0;
    while (!a_fin && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("run_a_timeout", {31'b0, a_fin}, 32'd1);
    check("reg_ac", {16'b0, a_ac}, {16'b0, exp_ac_q.pop_front()});
  endtask

  task automatic run_b(input int maxc);
    int n;
    @(negedge clk) b_start = 1'b1;
    @(negedge clk) b_start = 1'b0;
    n = 0;
    while (!b_fin && n < maxc) begin
      @(negedge clk);
      n++;
    end
    check("run_b_timeout", {31'b0, b_fin}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int cnt;
    for (int i = 0; i < 256; i++) begin
      dmem[i]  = '0;
      rom_b[i] = 16'hF000;
    end
    clear_rom_a();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    check("rst_imem_req", {31'b0, a_imem_req}, 32'd0);
    check("rst_mem_req", {31'b0, a_mem_req}, 32'd0);
    check("rst_busy_fin", {30'b0, a_busy, a_fin}, 32'd0);
    check("rst_err_z", {30'b0, a_err, a_z}, 32'd0);
    check("rst_ac", {16'b0, a_ac}, 32'd0);
    check("rst_addrs", {8'b0, a_imem_addr, a_mem_addr}, 32'd0);

    // Straight-line multiply with immediate ACK.
    rom_a[0] = 16'h1005; rom_a[1] = 16'h8000; rom_a[2] = 16'h1103;
    rom_a[3] = 16'h7100; rom_a[4] = 16'hF000;
    start_a();
    wait_a(16'd15, 100, n);
    check("mul_cycles", n, 10);
    check("mul_z", {31'b0, a_z}, 32'd0);
    check("mul_err", {31'b0, a_err}, 32'd0);
    check("mul_busy", {31'b0, a_busy}, 32'd0);

    // Store then load with three wait states on every access.
    idly = 3; ddly = 3;
    clear_rom_a();
    rom_a[0] = 16'h1240; rom_a[1] = 16'h4200; rom_a[2] = 16'h13AA; rom_a[3] = 16'h3300;
    rom_a[4] = 16'h2000; rom_a[5] = 16'h8000; rom_a[6] = 16'hF000;
    write_q.push_back({16'h0040, 16'h00AA});
    start_a();
    wait_a(16'h00AA, 300, n);
    check("dmem_40", {16'b0, dmem[8'h40]}, 32'h00AA);
    check("stores_drained", write_q.size(), 0);
    check("ldst_z", {31'b0, a_z}, 32'd0);

    // Countdown loop, then PC wrap 0xFF -> 0x00 lands on JZ which exits.
    idly = 0; ddly = 0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    clear_rom_a();
    rom_a[0] = 16'hB010; rom_a[1] = 16'h1003; rom_a[2] = 16'h8000; rom_a[3] = 16'h1101;
    rom_a[4] = 16'h6100; rom_a[5] = 16'hC004; rom_a[6] = 16'hD0FF;
    rom_a[8'hFF] = 16'h0000; rom_a[8'h10] = 16'hF000;
    sub_fetch = 0; wrap_seen = 1'b0;
    start_a();
    wait_a(16'd0, 200, n);
    check("loop_z", {31'b0, a_z}, 32'd1);
    check("loop_iterations", sub_fetch, 3);
    check("pc_wrap", {31'b0, wrap_seen}, 32'd1);

    // Illegal opcode traps before the LDAC can run.
    clear_rom_a();
    rom_a[0] = 16'h1007; rom_a[1] = 16'hE000; rom_a[2] = 16'h8000; rom_a[3] = 16'hF000;
    start_a();
    wait_a(16'd0, 100, n);
    check("ill_err", {31'b0, a_err}, 32'd1);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      cnt += int'(a_imem_req);
    end
    check("ill_no_fetch", cnt, 0);
    start_a();
    check("restart_err_clr", {31'b0, a_err}, 32'd0);
    check("restart_pc0", {23'b0, a_imem_req, a_imem_addr}, 32'h100);
    check("restart_fin_busy", {30'b0, a_fin, a_busy}, 32'd1);
    wait_a(16'd0, 100, n);
    check("ill_err_again", {31'b0, a_err}, 32'd1);

    // Out-of-range register and MUL trap on the reduced build.
    rom_b[0] = 16'h1104; rom_b[1] = 16'h8100; rom_b[2] = 16'h1509;
    rom_b[3] = 16'h8500; rom_b[4] = 16'hF000;
    run_b(100);
    check("oor_ac", {16'b0, b_ac}, 32'd0);
    check("oor_z", {31'b0, b_z}, 32'd1);
    check("oor_err", {31'b0, b_err}, 32'd0);
    rom_b[0] = 16'h1002; rom_b[1] = 16'h8000; rom_b[2] = 16'h7000; rom_b[3] = 16'hF000;
    rom_b[4] = 16'hF000;
    run_b(100);
    check("nomul_err", {31'b0, b_err}, 32'd1);
    check("nomul_ac", {16'b0, b_ac}, 32'd2);

    // Asynchronous reset while a load is waiting for its ACK.
    ddly = 10; len_chk_en = 1'b0;
    clear_rom_a();
    rom_a[0] = 16'h1121; rom_a[1] = 16'h8100; rom_a[2] = 16'h1250;
    rom_a[3] = 16'h4200; rom_a[4] = 16'h2000; rom_a[5] = 16'hF000;
    start_a();
    n = 0;
    while (!a_mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("mem_req_seen", {31'b0, a_mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("arst_reqs", {30'b0, a_imem_req, a_mem_req}, 32'd0);
    check("arst_flags", {28'b0, a_busy, a_fin, a_err, a_z}, 32'd0);
    check("arst_ac_addr", {a_ac, a_mem_addr}, 32'd0);
    @(negedge clk) rst = 1'b0;
    cnt = 0;
    repeat (5) begin
      @(negedge clk);
      cnt += int'(a_imem_req) + int'(a_busy);
    end
    check("arst_idle", cnt, 0);
    ddly = 0;
    @(negedge clk) len_chk_en = 1'b1;
    start_a();
    wait_a(16'h0021, 200, n);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/processing_core_param.md
Name: processing_core_param

Overview:
- Parametrised successor to the matrix-multiplication processing unit.
- A multicycle accumulator CPU with generic data/address width and a generic general-register count.
- Adds behaviour the earlier unit lacks:
  - request/acknowledge handshakes to instruction and data memory, so wait states are allowed;
  - START/DONE run control;
  - a hardware MUL op;
  - illegal-opcode trapping.
- Sits between the instruction ROM / data RAM wrappers and the top-level matrix-multiply controller.

Parameters:
- DATA_W, 16, width of AC, general registers, AR, data bus.
- IADDR_W, 8, PC / instruction address width.
- NUM_REGS, 4, number of general registers R0..R(NUM_REGS-1); legal range 1..16.
- MUL_EN, 1, 1 = MUL implemented; 0 = MUL traps as illegal.

Ports:
- MAIN_CLOCK  in  1  single clock, all state on rising edge.
- RESET  in  1  asynchronous, active-high; clears all state.
- START  in  1  level; sampled in IDLE and HALTED to begin a run at PC=0.
- IMEM_REQ  out  1  instruction fetch request.
- IMEM_ADDR  out  IADDR_W  fetch address (=PC).
- IMEM_DATA  in  16  instruction word: [15:12] opcode, [11:8] reg index n, [7:0] imm.
- IMEM_ACK  in  1  IMEM_DATA valid this cycle.
- MEM_REQ  out  1  data access request.
- MEM_WE  out  1  1 = write, valid with MEM_REQ.
- MEM_ADDR  out  DATA_W  =AR.
- MEM_WDATA  out  DATA_W  store data.
- MEM_RDATA  in  DATA_W  load data, valid with MEM_ACK.
- MEM_ACK  in  1  access complete.
- BUSY  out  1  high in FETCH/EXEC/MEM.
- PROCESS_FINISHED  out  1  high in HALTED.
- ERR  out  1  sticky illegal-opcode flag.
- Z_FLAG  out  1  zero flag.
- REG_AC  out  DATA_W  accumulator, for debug/observation.

Behaviour:
- Reset: state=IDLE; PC, IR, AC, AR, all Rn, Z_FLAG, ERR = 0; all REQ/WE = 0. Reset mid-transaction drops REQ asynchronously.
- FSM states: IDLE, FETCH, EXEC, MEM, HALTED.
- IDLE: START=1 -> PC=0, ERR=0, go to FETCH.
- FETCH:
  - IMEM_REQ=1 and IMEM_ADDR=PC, both held stable until IMEM_ACK.
  - On the ACK cycle: IR<=IMEM_DATA, PC<=PC+1 (wraps modulo 2^IADDR_W), go to EXEC.
  - Minimum 1 cycle with an immediate ACK.
- EXEC: one cycle, then FETCH unless noted. Ops by opcode:
  - 0 NOP.
  - 1 LDI: Rn = zero-extended imm.
  - 2 LDM: go to MEM (read).
  - 3 STM: go to MEM (write Rn).
  - 4 MVA: AR = Rn.
  - 5 ADD: AC = AC+Rn.
  - 6 SUB: AC = AC-Rn.
  - 7 MUL: AC = low DATA_W bits of AC*Rn.
  - 8 LDAC: AC = Rn.
  - 9 STAC: Rn = AC.
  - A INC: Rn = Rn+1.
  - B JZ: if Z_FLAG, PC = imm[IADDR_W-1:0].
  - C JNZ: if !Z_FLAG, PC = imm[IADDR_W-1:0].
  - D JMP: PC = imm[IADDR_W-1:0].
  - E: illegal.
  - F HALT: go to HALTED.
- Arithmetic: all results modulo 2^DATA_W; no carry/overflow output.
- Z_FLAG: updated only by ADD/SUB/MUL/LDAC, set to (new AC==0); held otherwise.
- Illegal ops: opcode E, or MUL with MUL_EN=0 -> ERR<=1, go to HALTED.
- Register index n >= NUM_REGS:
  - reads return 0;
  - writes are discarded;
  - not an error.
- MEM:
  - MEM_REQ=1 with MEM_ADDR=AR; MEM_WE and MEM_WDATA=Rn held stable until MEM_ACK.
  - On ACK: for a load, Rn<=MEM_RDATA; then deassert REQ and go to FETCH.
  - REQ is never asserted in two consecutive transactions without one deasserted cycle between them.
- HALTED:
  - PROCESS_FINISHED=1 and BUSY=0.
  - Registers hold their values, so the host can read REG_AC.
  - START=1 -> PC=0, ERR=0, go to FETCH. Registers are not cleared.
- Protocol guards:
  - IMEM_ACK is ignored outside FETCH; MEM_ACK is ignored outside MEM.
  - IMEM_REQ and MEM_REQ are never asserted together.
- START held high continuously: HALTED is occupied for exactly 1 cycle before the restart.

Test Plan:
- Reset then immediate-ACK memories; program LDI R0,5; LDAC R0; LDI R1,3; MUL R1; HALT -> REG_AC=15, Z_FLAG=0, PROCESS_FINISHED rises 1 cycle after the HALT EXEC, ERR=0.
- Store/load with wait states: ACK delayed 3 cycles on every access; LDI R2,0x40; MVA R2; LDI R3,0xAA; STM R3; LDM R0; LDAC R0; HALT -> MEM_REQ held exactly 4 cycles per access with stable addr/we/wdata, mem[0x40]=0xAA, REG_AC=0x00AA.
- Loop and branch: R0=3 as counter, AC=3, SUB R1 (R1=1) with JNZ back -> loop executes 3 times, exits with Z_FLAG=1, AC=0; PC wrap from 0xFF to 0x00 verified with JMP 0xFF placing NOP at 0xFF.
- Illegal op: opcode E mid-program, and MUL with MUL_EN=0 build -> ERR=1, PROCESS_FINISHED=1, no further IMEM_REQ; START clears ERR and refetches from PC=0.
- Out-of-range register: NUM_REGS=2; LDI R5,9; LDAC R5 -> AC=0, Z_FLAG=1, ERR=0.
- Async reset asserted during MEM with REQ high -> MEM_REQ/IMEM_REQ drop in the same cycle, all outputs at reset values, state IDLE until START.
